// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the program counter, drives the program-memory address and
// buffers {pc, instruction} pairs in a DEPTH-entry FIFO drained by valid/ready.
module instruction_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           fetch_enable,
    output logic [ADDR_WIDTH-1:0]          mem_adr,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_target,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [DATA_WIDTH-1:0]          inst_data,
    output logic [ADDR_WIDTH-1:0]          inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Full is judged on the registered count only, so a pop never frees a
    // slot for a push in the same cycle and inst_ready stays off this path.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = ~w_empty & inst_ready;
    assign w_push  = fetch_enable & ~w_full & ~redirect_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            // A pop in this cycle still counts as delivered; its entry is dropped.
            r_fetch_pc <= redirect_target;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail     <= r_tail + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once
    // count marks them valid, and leaving reset off lets it map to plain RAM.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= r_fetch_pc;
            r_data_mem[r_tail] <= mem_data;
        end
    end

    assign mem_adr    = r_fetch_pc;
    assign inst_valid = ~w_empty;
    assign inst_data  = r_data_mem[r_head];
    assign inst_pc    = r_pc_mem[r_head];
    assign count      = r_count;

endmodule
